// File: rtl/csr_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : csr_pkg                                                         |
// | Purpose  : Shared definitions for the machine-mode CSR bank: CSR address    |
// |            map, csr_op encodings, read-only ID constants, FSM state type    |
// |            and the misa value helper.                                       |
// | Ports    : none (package)                                                  |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package csr_pkg;

  // CSR address map
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MIMPID    = 12'hF13;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  typedef enum logic [1:0] {
    CSR_OP_READ  = 2'b00,
    CSR_OP_WRITE = 2'b01,
    CSR_OP_SET   = 2'b10,
    CSR_OP_CLEAR = 2'b11
  } csr_op_e;

  // Read-only identification values
  localparam logic [31:0] MVENDORID_VALUE = 32'h5256_4B43;
  localparam logic [31:0] MARCHID_VALUE   = 32'h0000_0000;
  localparam logic [31:0] MIMPID_VALUE    = 32'h0000_0001;

  // mstatus field positions
  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } csr_state_e;

  // misa: MXL in the top two bits (1 = RV32, 2 = RV64) plus the I extension.
  function automatic logic [63:0] misa_value(input int unsigned xlen);
    logic [63:0] v;
    v    = '0;
    v[8] = 1'b1;
    if (xlen == 64) v[63:62] = 2'b10;
    else            v[31:30] = 2'b01;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/csr_counter64.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : csr_counter64                                                   |
// | Purpose  : 64-bit free-running event counter with independent 32-bit       |
// |            half writes. A write to either half overrides the increment     |
// |            for that edge; the unwritten half holds. Wraps 2^64-1 -> 0.     |
// | Ports    : clk, reset_n   - clock, async active-low reset                  |
// |            inc_i          - count enable for this edge                     |
// |            wr_lo_i/wr_hi_i, wdata_lo_i/wdata_hi_i - half writes            |
// |            count_o        - current 64-bit count                           |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module csr_counter64 (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        inc_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_lo_i,
  input  logic [31:0] wdata_hi_i,
  output logic [63:0] count_o
);

  logic [63:0] count_q;
  logic [63:0] count_d;

  always_comb begin
    count_d = count_q;
    if (wr_lo_i || wr_hi_i) begin
      if (wr_lo_i) count_d[31:0]  = wdata_lo_i;
      if (wr_hi_i) count_d[63:32] = wdata_hi_i;
    end else if (inc_i) begin
      count_d = count_q + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/csr_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : csr_bank                                                        |
// | Purpose  : Machine-mode CSR bank with a one-request-per-two-cycles         |
// |            read/write/set/clear interface, trap entry/return handling      |
// |            and mcycle/minstret counters.                                   |
// | Ports    : clk, reset_n                        - clock, async low reset    |
// |            csr_req_valid/ready, csr_op,                                    |
// |            csr_address, csr_write_data         - request                   |
// |            csr_rsp_valid, csr_read_out,                                    |
// |            csr_illegal                         - response (1 cycle later)  |
// |            trap_valid, trap_pc/cause/value     - trap entry                |
// |            mret, instret_pulse                 - trap return, retire       |
// |            mtvec_out, mepc_out, mie_out        - live CSR values           |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module csr_bank
  import csr_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_1000,
  parameter logic [31:0] HART_ID     = 32'h524B_4330,
  parameter int unsigned COUNTERS_EN = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            csr_req_valid,
  output logic            csr_req_ready,
  input  logic [1:0]      csr_op,
  input  logic [11:0]     csr_address,
  input  logic [XLEN-1:0] csr_write_data,
  output logic            csr_rsp_valid,
  output logic [XLEN-1:0] csr_read_out,
  output logic            csr_illegal,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_value,
  input  logic            mret,
  input  logic            instret_pulse,
  output logic [XLEN-1:0] mtvec_out,
  output logic [XLEN-1:0] mepc_out,
  output logic            mie_out
);

  localparam logic [63:0] MISA_FULL = misa_value(XLEN);

  csr_state_e state_q, state_d;

  logic [XLEN-1:0] read_out_q, read_out_d;
  logic            illegal_q,  illegal_d;
  logic [XLEN-1:0] mtvec_q,    mtvec_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q,     mepc_d;
  logic [XLEN-1:0] mcause_q,   mcause_d;
  logic [XLEN-1:0] mtval_q,    mtval_d;
  logic            mie_q,      mie_d;
  logic            mpie_q,     mpie_d;

  logic [63:0]     mcycle;
  logic [63:0]     minstret;
  logic [XLEN-1:0] mstatus_val;
  logic [XLEN-1:0] old_val;
  logic [XLEN-1:0] new_val;
  logic            addr_legal;
  logic            addr_ro;
  logic            accept;
  logic            wr_intent;
  logic            req_illegal;
  logic            commit;
  logic [31:0]     cnt_wdata_hi;
  logic            cyc_hi_sel;
  logic            ins_hi_sel;

  // ---------------------------------------------------------------- FSM
  always_comb begin
    state_d       = state_q;
    csr_req_ready = 1'b0;
    csr_rsp_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        csr_req_ready = 1'b1;
        if (csr_req_valid) state_d = ST_RESP;
      end
      ST_RESP: begin
        csr_rsp_valid = 1'b1;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign accept = (state_q == ST_IDLE) && csr_req_valid;

  // ------------------------------------------------------- read decode
  always_comb begin
    mstatus_val                   = '0;
    mstatus_val[MSTATUS_MIE_BIT]  = mie_q;
    mstatus_val[MSTATUS_MPIE_BIT] = mpie_q;
    mstatus_val[12:11]            = 2'b11;   // MPP: machine mode only
  end

  always_comb begin
    addr_legal = 1'b1;
    addr_ro    = 1'b0;
    old_val    = '0;
    case (csr_address)
      CSR_MVENDORID: begin old_val = XLEN'(MVENDORID_VALUE); addr_ro = 1'b1; end
      CSR_MARCHID:   begin old_val = XLEN'(MARCHID_VALUE);   addr_ro = 1'b1; end
      CSR_MIMPID:    begin old_val = XLEN'(MIMPID_VALUE);    addr_ro = 1'b1; end
      CSR_MHARTID:   begin old_val = XLEN'(HART_ID);         addr_ro = 1'b1; end
      CSR_MSTATUS:   old_val = mstatus_val;
      CSR_MISA:      old_val = MISA_FULL[XLEN-1:0];   // writes accepted, ignored
      CSR_MTVEC:     old_val = mtvec_q;
      CSR_MSCRATCH:  old_val = mscratch_q;
      CSR_MEPC:      old_val = mepc_q;
      CSR_MCAUSE:    old_val = mcause_q;
      CSR_MTVAL:     old_val = mtval_q;
      CSR_MCYCLE: begin
        if (COUNTERS_EN != 0) old_val = mcycle[XLEN-1:0];
        else                  addr_legal = 1'b0;
      end
      CSR_MINSTRET: begin
        if (COUNTERS_EN != 0) old_val = minstret[XLEN-1:0];
        else                  addr_legal = 1'b0;
      end
      CSR_MCYCLEH: begin
        if (COUNTERS_EN != 0 && XLEN == 32) old_val = XLEN'(mcycle[63:32]);
        else                                addr_legal = 1'b0;
      end
      CSR_MINSTRETH: begin
        if (COUNTERS_EN != 0 && XLEN == 32) old_val = XLEN'(minstret[63:32]);
        else                                addr_legal = 1'b0;
      end
      default: addr_legal = 1'b0;
    endcase
  end

  // ---------------------------------------------------- write operand
  always_comb begin
    new_val = old_val;
    case (csr_op)
      CSR_OP_WRITE: new_val = csr_write_data;
      CSR_OP_SET:   new_val = old_val | csr_write_data;
      CSR_OP_CLEAR: new_val = old_val & ~csr_write_data;
      default:      new_val = old_val;
    endcase
  end

  // set/clear with a zero mask is a pure read and must not fault on RO CSRs
  assign wr_intent   = (csr_op == CSR_OP_WRITE) ||
                       (((csr_op == CSR_OP_SET) || (csr_op == CSR_OP_CLEAR)) &&
                        (csr_write_data != '0));
  assign req_illegal = !addr_legal || (addr_ro && wr_intent);
  assign commit      = accept && wr_intent && !req_illegal;

  // ------------------------------------------------ CSR next state
  always_comb begin
    read_out_d = read_out_q;
    illegal_d  = illegal_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    mie_d      = mie_q;
    mpie_d     = mpie_q;

    if (accept) begin
      illegal_d  = req_illegal;
      read_out_d = req_illegal ? '0 : old_val;
    end

    if (commit) begin
      case (csr_address)
        CSR_MSTATUS: begin
          mie_d  = new_val[MSTATUS_MIE_BIT];
          mpie_d = new_val[MSTATUS_MPIE_BIT];
        end
        CSR_MTVEC:    mtvec_d    = {new_val[XLEN-1:2], 2'b00};
        CSR_MSCRATCH: mscratch_d = new_val;
        CSR_MEPC:     mepc_d     = {new_val[XLEN-1:2], 2'b00};
        CSR_MCAUSE:   mcause_d   = new_val;
        CSR_MTVAL:    mtval_d    = new_val;
        default: ;
      endcase
    end

    // Evaluated after the CSR write so trap entry and mret take precedence
    // over a same-edge write to the trap CSRs; unrelated writes still land.
    if (trap_valid) begin
      mepc_d   = trap_pc;
      mcause_d = trap_cause;
      mtval_d  = trap_value;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end else if (mret) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      read_out_q <= '0;
      illegal_q  <= 1'b0;
      mtvec_q    <= XLEN'(MTVEC_RESET);
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      read_out_q <= read_out_d;
      illegal_q  <= illegal_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
    end
  end

  // ------------------------------------------------------- counters
  // On RV64 the low address covers both halves; on RV32 the upper half has
  // its own address.
  if (XLEN == 64) begin : g_cnt_hi64
    assign cnt_wdata_hi = new_val[XLEN-1:32];
    assign cyc_hi_sel   = (csr_address == CSR_MCYCLE);
    assign ins_hi_sel   = (csr_address == CSR_MINSTRET);
  end else begin : g_cnt_hi32
    assign cnt_wdata_hi = new_val[31:0];
    assign cyc_hi_sel   = (csr_address == CSR_MCYCLEH);
    assign ins_hi_sel   = (csr_address == CSR_MINSTRETH);
  end

  if (COUNTERS_EN != 0) begin : g_counters
    csr_counter64 u_mcycle (
      .clk        (clk),
      .reset_n    (reset_n),
      .inc_i      (1'b1),
      .wr_lo_i    (commit && (csr_address == CSR_MCYCLE)),
      .wr_hi_i    (commit && cyc_hi_sel),
      .wdata_lo_i (new_val[31:0]),
      .wdata_hi_i (cnt_wdata_hi),
      .count_o    (mcycle)
    );

    csr_counter64 u_minstret (
      .clk        (clk),
      .reset_n    (reset_n),
      .inc_i      (instret_pulse),
      .wr_lo_i    (commit && (csr_address == CSR_MINSTRET)),
      .wr_hi_i    (commit && ins_hi_sel),
      .wdata_lo_i (new_val[31:0]),
      .wdata_hi_i (cnt_wdata_hi),
      .count_o    (minstret)
    );
  end else begin : g_no_counters
    assign mcycle   = '0;
    assign minstret = '0;
  end

  // ------------------------------------------------------- outputs
  assign csr_read_out = read_out_q;
  assign csr_illegal  = illegal_q;
  assign mtvec_out    = mtvec_q;
  assign mepc_out     = mepc_q;
  assign mie_out      = mie_q;

endmodule
`default_nettype wire
